alu_trace_serializer: RTL

ALU_TRACE_SERIALIZER -- requirements
Module: alu_trace_serializer

---
 rtl/alu_trace_pkg.sv | 25 ++
 rtl/alu_trace_fifo.sv | 47 ++++
 rtl/alu_trace_serializer.sv | 95 +++++++++
 3 files changed

// File: rtl/alu_trace_pkg.sv
// Shared field tags and record geometry for the ALU trace serializer.
// Optional macro ALU_TRACE_SEQ_EN appends an 8-bit sequence-number field.
package alu_trace_pkg;
  localparam logic [2:0] FLD_OPCODE = 3'd0;
  localparam logic [2:0] FLD_A      = 3'd1;
  localparam logic [2:0] FLD_B      = 3'd2;
  localparam logic [2:0] FLD_RESULT = 3'd3;
  localparam logic [2:0] FLD_CARRY  = 3'd4;
  localparam logic [2:0] FLD_BORROW = 3'd5;
  localparam logic [2:0] FLD_PC     = 3'd6;
  localparam logic [2:0] FLD_SEQ    = 3'd7;
`ifdef ALU_TRACE_SEQ_EN
  localparam int unsigned NUM_FIELDS = 8;
  localparam int unsigned SEQ_W      = 8;
`else
  localparam int unsigned NUM_FIELDS = 7;
  localparam int unsigned SEQ_W      = 0;
`endif
  localparam logic [2:0] FLD_LAST = 3'(NUM_FIELDS - 1);

  // Packed record: {seq?, pc, borrow, carry, result, b, a, opcode}
  function automatic int unsigned rec_width(input int unsigned dw, input int unsigned pw);
    return 8 + 3 * dw + 2 + pw + SEQ_W;
  endfunction
endpackage

// File: rtl/alu_trace_fifo.sv
// Record buffer for the trace serializer: power-of-two circular FIFO.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module alu_trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_cnt;
  logic          w_push, w_pop;

  assign full   = (r_cnt == LW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign level  = r_cnt;
  assign dout   = r_mem[r_rd];
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push & ~w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop & ~w_push) r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/alu_trace_serializer.sv
// Buffers ALU execution records and streams them one field per accepted word.
// Define ALU_TRACE_SEQ_EN to append a per-record sequence number as field 7.
module alu_trace_serializer import alu_trace_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rec_valid,
  input  logic [7:0]                 opcode_in,
  input  logic [DATA_W-1:0]          operand_a_in,
  input  logic [DATA_W-1:0]          operand_b_in,
  input  logic [DATA_W-1:0]          result_in,
  input  logic                       carry_in,
  input  logic                       borrow_in,
  input  logic [PC_W-1:0]            pc_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          data_out,
  output logic [2:0]                 data_type,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     level,
  output logic [7:0]                 drop_cnt
);
  localparam int REC_W = rec_width(DATA_W, PC_W);
  localparam int O_A   = 8;
  localparam int O_B   = O_A + DATA_W;
  localparam int O_R   = O_B + DATA_W;
  localparam int O_C   = O_R + DATA_W;
  localparam int O_BR  = O_C + 1;
  localparam int O_PC  = O_C + 2;

  logic [REC_W-1:0]  w_din, w_head;
  logic              w_full, w_empty, w_acc, w_last, w_pop;
  logic [DATA_W-1:0] w_data;
  logic [2:0]        r_fld;
  logic [7:0]        r_drop;

`ifdef ALU_TRACE_SEQ_EN
  localparam int O_SEQ = O_PC + PC_W;
  logic [7:0] r_seq;
  assign w_din = {r_seq, pc_in, borrow_in, carry_in, result_in, operand_b_in, operand_a_in, opcode_in};
`else
  assign w_din = {pc_in, borrow_in, carry_in, result_in, operand_b_in, operand_a_in, opcode_in};
`endif

  alu_trace_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(rec_valid), .pop(w_pop), .din(w_din),
    .dout(w_head), .full(w_full), .empty(w_empty), .level(level)
  );

  assign out_valid = ~w_empty;
  assign w_last    = (r_fld == FLD_LAST);
  assign w_acc     = out_valid & out_ready;
  assign w_pop     = w_acc & w_last;
  assign out_last  = w_last & out_valid;
  assign data_out  = out_valid ? w_data : '0;
  assign data_type = out_valid ? r_fld : 3'd0;
  assign drop_cnt  = r_drop;

  always_comb begin
    w_data = '0;
    case (r_fld)
      FLD_OPCODE: w_data = DATA_W'(w_head[7:0]);
      FLD_A:      w_data = w_head[O_A +: DATA_W];
      FLD_B:      w_data = w_head[O_B +: DATA_W];
      FLD_RESULT: w_data = w_head[O_R +: DATA_W];
      FLD_CARRY:  w_data = DATA_W'(w_head[O_C]);
      FLD_BORROW: w_data = DATA_W'(w_head[O_BR]);
      FLD_PC:     w_data = DATA_W'(w_head[O_PC +: PC_W]);
`ifdef ALU_TRACE_SEQ_EN
      FLD_SEQ:    w_data = DATA_W'(w_head[O_SEQ +: 8]);
`endif
      default:    w_data = '0;
    endcase
  end

  // A strobe into a full buffer is only lost if the head is not retiring now.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fld  <= '0;
      r_drop <= '0;
`ifdef ALU_TRACE_SEQ_EN
      r_seq  <= '0;
`endif
    end else begin
      if (w_acc) r_fld <= w_last ? 3'd0 : r_fld + 3'd1;
      if (rec_valid & w_full & ~w_pop & (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
`ifdef ALU_TRACE_SEQ_EN
      if (rec_valid & (~w_full | w_pop)) r_seq <= r_seq + 8'd1;
`endif
    end
  end
endmodule
